// File: rtl/fruit_launcher.sv
// ============================================================================
// Module   : fruit_launcher
// Function : Ballistic fruit sprite with launch, frame-tick motion, slicing
//            into two halves and miss detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fruit_launcher #(
    parameter int WIDTH    = 150,
    parameter int HEIGHT   = 150,
    parameter int SCREEN_W = 1024,
    parameter int SCREEN_H = 768,
    parameter int GRAVITY  = 1,
    parameter int SPLIT_DX = 4
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              launch,
    input  logic [10:0]       launch_x,
    input  logic signed [4:0] launch_vx,
    input  logic [5:0]        launch_vy,
    input  logic              slice_hit,
    output logic [10:0]       x,
    output logic [9:0]        y,
    output logic [10:0]       xslice,
    output logic [9:0]        yslice,
    output logic [2:0]        slice,
    output logic              active,
    output logic              busy,
    output logic              sliced_evt,
    output logic              missed_evt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLYING = 2'd1,
        S_SPLIT  = 2'd2
    } state_t;

    localparam logic [10:0]        c_X_MAX    = 11'(SCREEN_W - WIDTH);
    localparam logic signed [11:0] c_X_MAX12  = 12'(SCREEN_W - WIDTH);
    localparam logic [11:0]        c_H12      = 12'(SCREEN_H);
    localparam logic [9:0]         c_Y_LAUNCH = (SCREEN_H > 1023) ? 10'd1023 : 10'(SCREEN_H);
    localparam logic signed [11:0] c_DX12     = 12'(SPLIT_DX);
    localparam logic signed [8:0]  c_GRAV9    = 9'(GRAVITY);

    if ((WIDTH <= 0) || (HEIGHT <= 0) || (WIDTH >= SCREEN_W)) begin : g_param_check
        $error("fruit_launcher: sprite dimensions incompatible with screen");
    end

    state_t             r_state, w_state_nx;
    logic [10:0]        r_x, r_xs, w_x_nx, w_xs_nx;
    logic [9:0]         r_y, r_ys, w_y_nx, w_ys_nx;
    logic signed [4:0]  r_vx, w_vx_nx;
    logic signed [7:0]  r_vy, w_vy_nx, w_vy_base, w_vy_sat;
    logic signed [8:0]  w_vy_dec;
    logic [2:0]         r_slice, w_slice_nx;
    logic               r_active, r_busy, r_sliced, r_missed, r_vsync_d;
    logic               w_active_nx, w_busy_nx, w_sliced_nx, w_missed_nx, w_tick;
    logic signed [11:0] w_y_raw, w_ys_raw, w_x_raw, w_xs_raw, w_xl_raw;

    function automatic logic [9:0] f_sat_y(input logic signed [11:0] v);
        if (v[11])              return 10'd0;
        else if (v > 12'sd1023) return 10'd1023;
        else                    return v[9:0];
    endfunction

    function automatic logic [10:0] f_clamp_x(input logic signed [11:0] v);
        if (v[11])               return 11'd0;
        else if (v > c_X_MAX12)  return c_X_MAX;
        else                     return v[10:0];
    endfunction

    assign w_tick   = vsync & ~r_vsync_d;
    assign w_y_raw  = $signed({2'b00, r_y})  - $signed({{4{r_vy[7]}}, r_vy});
    assign w_ys_raw = $signed({2'b00, r_ys}) - $signed({{4{r_vy[7]}}, r_vy});
    assign w_x_raw  = $signed({1'b0, r_x}) + $signed({{7{r_vx[4]}}, r_vx});
    assign w_xl_raw = $signed({1'b0, r_x})  + c_DX12;
    assign w_xs_raw = $signed({1'b0, r_xs}) - c_DX12;

    // A half hitting the top of the screen kills upward speed before gravity acts.
    assign w_vy_base = (w_y_raw[11] || ((r_state == S_SPLIT) && w_ys_raw[11])) ? 8'sd0 : r_vy;
    assign w_vy_dec  = $signed({w_vy_base[7], w_vy_base}) - c_GRAV9;
    assign w_vy_sat  = (w_vy_dec[8] != w_vy_dec[7]) ? (w_vy_dec[8] ? 8'sh80 : 8'sh7F)
                                                    : w_vy_dec[7:0];

    always_comb begin
        w_state_nx  = r_state;
        w_x_nx      = r_x;
        w_y_nx      = r_y;
        w_xs_nx     = r_xs;
        w_ys_nx     = r_ys;
        w_vx_nx     = r_vx;
        w_vy_nx     = r_vy;
        w_slice_nx  = r_slice;
        w_active_nx = r_active;
        w_busy_nx   = r_busy;
        w_sliced_nx = 1'b0;
        w_missed_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (launch) begin
                    w_state_nx  = S_FLYING;
                    w_x_nx      = (launch_x > c_X_MAX) ? c_X_MAX : launch_x;
                    w_y_nx      = c_Y_LAUNCH;
                    w_vx_nx     = launch_vx;
                    w_vy_nx     = $signed({2'b00, launch_vy});
                    w_active_nx = 1'b1;
                    w_busy_nx   = 1'b1;
                    w_slice_nx  = 3'd0;
                end
            end
            S_FLYING: begin
                if (w_tick) begin
                    w_x_nx  = f_clamp_x(w_x_raw);
                    w_y_nx  = f_sat_y(w_y_raw);
                    w_vy_nx = w_vy_sat;
                    if (w_x_raw[11] || (w_x_raw > c_X_MAX12)) begin
                        w_vx_nx = 5'sd0;
                    end
                end
                // A slice wins over a miss detected on the same tick.
                if (slice_hit) begin
                    w_state_nx  = S_SPLIT;
                    w_slice_nx  = 3'd1;
                    w_xs_nx     = w_x_nx;
                    w_ys_nx     = w_y_nx;
                    w_sliced_nx = 1'b1;
                end else if (w_tick && w_vy_sat[7] && ({2'b00, w_y_nx} >= c_H12)) begin
                    w_state_nx  = S_IDLE;
                    w_active_nx = 1'b0;
                    w_busy_nx   = 1'b0;
                    w_missed_nx = 1'b1;
                end
            end
            S_SPLIT: begin
                if (w_tick) begin
                    w_x_nx  = f_clamp_x(w_xl_raw);
                    w_xs_nx = f_clamp_x(w_xs_raw);
                    w_y_nx  = f_sat_y(w_y_raw);
                    w_ys_nx = f_sat_y(w_ys_raw);
                    w_vy_nx = w_vy_sat;
                    if (w_vy_sat[7] && ({2'b00, w_y_nx} >= c_H12) && ({2'b00, w_ys_nx} >= c_H12)) begin
                        w_state_nx  = S_IDLE;
                        w_active_nx = 1'b0;
                        w_busy_nx   = 1'b0;
                        w_slice_nx  = 3'd0;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_xs      <= '0;
            r_ys      <= '0;
            r_vx      <= '0;
            r_vy      <= '0;
            r_slice   <= '0;
            r_active  <= 1'b0;
            r_busy    <= 1'b0;
            r_sliced  <= 1'b0;
            r_missed  <= 1'b0;
            r_vsync_d <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_x       <= w_x_nx;
            r_y       <= w_y_nx;
            r_xs      <= w_xs_nx;
            r_ys      <= w_ys_nx;
            r_vx      <= w_vx_nx;
            r_vy      <= w_vy_nx;
            r_slice   <= w_slice_nx;
            r_active  <= w_active_nx;
            r_busy    <= w_busy_nx;
            r_sliced  <= w_sliced_nx;
            r_missed  <= w_missed_nx;
            r_vsync_d <= vsync;
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign xslice     = r_xs;
    assign yslice     = r_ys;
    assign slice      = r_slice;
    assign active     = r_active;
    assign busy       = r_busy;
    assign sliced_evt = r_sliced;
    assign missed_evt = r_missed;

endmodule

`default_nettype wire

// File: tb/tb_fruit_launcher.sv
// ============================================================================
// Module   : tb_fruit_launcher
// Function : Self-checking bench for fruit_launcher (vector table, cycle
//            scoreboard and hand-written corner-case sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fruit_launcher;

    localparam int XMAX = 874;
    localparam int SH   = 768;

    logic              clk = 1'b0;
    logic              rst, vsync, launch, slice_hit;
    logic [10:0]       launch_x;
    logic signed [4:0] launch_vx;
    logic [5:0]        launch_vy;
    logic [10:0]       x, xslice;
    logic [9:0]        y, yslice;
    logic [2:0]        slice;
    logic              active, busy, sliced_evt, missed_evt;

    always #5 clk = ~clk;

    fruit_launcher dut (
        .pixel_clk (clk),
        .reset     (rst),
        .vsync     (vsync),
        .launch    (launch),
        .launch_x  (launch_x),
        .launch_vx (launch_vx),
        .launch_vy (launch_vy),
        .slice_hit (slice_hit),
        .x         (x),
        .y         (y),
        .xslice    (xslice),
        .yslice    (yslice),
        .slice     (slice),
        .active    (active),
        .busy      (busy),
        .sliced_evt(sliced_evt),
        .missed_evt(missed_evt)
    );

    typedef struct { int x, y, xs, ys, slice, act, busy, sl, ms; } exp_t;
    typedef struct { bit r, l, t; int lx, lvx, lvy, ex, ey, eact, ebusy; } vec_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   miss_cnt = 0;
    int   slc_cnt  = 0;

    // Reference model state
    int m_state, m_x, m_y, m_xs, m_ys, m_vx, m_vy, m_slice, m_act, m_busy, m_sl, m_ms;
    bit m_vs_d;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit l, input int lx, input int lvx,
                              input int lvy, input bit hit, input bit vs);
        bit tk;
        int ny, nys, nvy, nx;
        if (r) begin
            m_state = 0; m_x = 0; m_y = 0; m_xs = 0; m_ys = 0; m_vx = 0; m_vy = 0;
            m_slice = 0; m_act = 0; m_busy = 0; m_sl = 0; m_ms = 0; m_vs_d = 0;
            return;
        end
        tk = vs && !m_vs_d;
        m_vs_d = vs;
        m_sl = 0;
        m_ms = 0;
        case (m_state)
            0: if (l) begin
                m_state = 1; m_x = (lx > XMAX) ? XMAX : lx; m_y = SH;
                m_vx = lvx; m_vy = lvy; m_act = 1; m_busy = 1; m_slice = 0;
            end
            1: begin
                if (tk) begin
                    ny = m_y - m_vy; nvy = m_vy;
                    if (ny < 0) begin ny = 0; nvy = 0; end
                    if (ny > 1023) ny = 1023;
                    nvy = nvy - 1;
                    nx = m_x + m_vx;
                    if (nx < 0) begin nx = 0; m_vx = 0; end
                    else if (nx > XMAX) begin nx = XMAX; m_vx = 0; end
                    m_x = nx; m_y = ny; m_vy = nvy;
                end
                if (hit) begin
                    m_state = 2; m_slice = 1; m_xs = m_x; m_ys = m_y; m_sl = 1;
                end else if (tk && m_vy < 0 && m_y >= SH) begin
                    m_state = 0; m_act = 0; m_busy = 0; m_ms = 1;
                end
            end
            2: if (tk) begin
                ny = m_y - m_vy; nys = m_ys - m_vy; nvy = m_vy;
                if (ny < 0 || nys < 0) nvy = 0;
                if (ny < 0) ny = 0;
                if (nys < 0) nys = 0;
                if (ny > 1023) ny = 1023;
                if (nys > 1023) nys = 1023;
                m_y = ny; m_ys = nys; m_vy = nvy - 1;
                m_x  = (m_x + 4 > XMAX) ? XMAX : m_x + 4;
                m_xs = (m_xs - 4 < 0) ? 0 : m_xs - 4;
                if (m_vy < 0 && m_y >= SH && m_ys >= SH) begin
                    m_state = 0; m_act = 0; m_busy = 0; m_slice = 0;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic compare_pop();
        exp_t e;
        e = q.pop_front();
        n_checks++;
        if (int'(x) != e.x || int'(y) != e.y || int'(xslice) != e.xs || int'(yslice) != e.ys ||
            int'(slice) != e.slice || int'(active) != e.act || int'(busy) != e.busy ||
            int'(sliced_evt) != e.sl || int'(missed_evt) != e.ms) begin
            n_fail++;
            $display("FAIL scoreboard t=%0t got x=%0d y=%0d xs=%0d ys=%0d sl=%0d a=%0d b=%0d se=%0d me=%0d expected x=%0d y=%0d xs=%0d ys=%0d sl=%0d a=%0d b=%0d se=%0d me=%0d",
                     $time, x, y, xslice, yslice, slice, active, busy, sliced_evt, missed_evt,
                     e.x, e.y, e.xs, e.ys, e.slice, e.act, e.busy, e.sl, e.ms);
        end
    endtask

    task automatic drive(input bit r, input bit l, input int lx, input int lvx,
                         input int lvy, input bit hit, input bit vs);
        rst = r; launch = l; launch_x = 11'(lx); launch_vx = 5'(lvx); launch_vy = 6'(lvy);
        slice_hit = hit; vsync = vs;
        model_edge(r, l, lx, lvx, lvy, hit, vs);
        q.push_back('{m_x, m_y, m_xs, m_ys, m_slice, m_act, m_busy, m_sl, m_ms});
        @(posedge clk);
        #1;
        compare_pop();
        miss_cnt += int'(missed_evt);
        slc_cnt  += int'(sliced_evt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick_frame(input bit hit);
        drive(0, 0, 0, 0, 0, hit, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        miss_cnt = 0;
        slc_cnt  = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        int   k, done_k;
        int   ef[4];

        // Launch/3 ticks trajectory, then edge clamp and an ignored relaunch.
        vt[0] = '{0, 1, 0, 400,  2, 20, 400, 768, 1, 1};
        vt[1] = '{0, 0, 1,   0,  0,  0, 402, 748, 1, 1};
        vt[2] = '{0, 0, 1,   0,  0,  0, 404, 729, 1, 1};
        vt[3] = '{0, 0, 1,   0,  0,  0, 406, 711, 1, 1};
        vt[4] = '{1, 0, 0,   0,  0,  0,   0,   0, 0, 0};
        vt[5] = '{0, 1, 0, 1000, 5, 30, 874, 768, 1, 1};
        vt[6] = '{0, 0, 1,   0,  0,  0, 874, 738, 1, 1};
        vt[7] = '{0, 1, 0,  10,  0,  5, 874, 738, 1, 1};
        vt[8] = '{0, 0, 1,   0,  0,  0, 874, 709, 1, 1};
        ef    = '{0, 1, 3, 6};

        m_vs_d = 0;
        // Reset dominates a concurrent launch.
        drive(1, 1, 400, 2, 20, 1, 1);
        drive(1, 1, 400, 2, 20, 1, 0);
        chk("reset_x", int'(x), 0);
        chk("reset_y", int'(y), 0);
        chk("reset_active", int'(active), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_slice", int'(slice), 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            if (vt[i].t)      tick_frame(0);
            else if (vt[i].r) do_reset();
            else              drive(0, vt[i].l, vt[i].lx, vt[i].lvx, vt[i].lvy, 0, 0);
            chk($sformatf("vec%0d_x", i), int'(x), vt[i].ex);
            chk($sformatf("vec%0d_y", i), int'(y), vt[i].ey);
            chk($sformatf("vec%0d_active", i), int'(active), vt[i].eact);
            chk($sformatf("vec%0d_busy", i), int'(busy), vt[i].ebusy);
        end

        // Miss after a full arc: y returns to 768 on tick 41 with vy=-21.
        do_reset();
        drive(0, 1, 400, 0, 20, 0, 0);
        done_k = -1;
        for (k = 1; k <= 60 && done_k < 0; k++) begin
            tick_frame(0);
            if (!busy) done_k = k;
        end
        chk("miss_tick", done_k, 41);
        idle(3);
        chk("miss_pulses", miss_cnt, 1);
        chk("miss_active", int'(active), 0);
        chk("miss_busy", int'(busy), 0);

        // Slice after 5 ticks, halves separate, then reset mid-split.
        do_reset();
        drive(0, 1, 400, 2, 20, 0, 0);
        for (int i = 0; i < 5; i++) tick_frame(0);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("slice_code", int'(slice), 1);
        chk("slice_xs", int'(xslice), 410);
        chk("slice_ys", int'(yslice), 678);
        chk("slice_evt", int'(sliced_evt), 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("slice_evt_pulse", int'(sliced_evt), 0);
        tick_frame(1);
        chk("split_dx", int'(xslice) - int'(x), -8);
        chk("split_y", int'(y), 663);
        chk("split_hit_ignored", slc_cnt, 1);
        drive(1, 1, 300, 3, 10, 1, 1);
        chk("midsplit_rst_x", int'(x), 0);
        chk("midsplit_rst_xs", int'(xslice), 0);
        chk("midsplit_rst_ys", int'(yslice), 0);
        chk("midsplit_rst_slice", int'(slice), 0);
        chk("midsplit_rst_busy", int'(busy), 0);
        drive(0, 1, 100, -3, 10, 0, 0);
        chk("relaunch_x", int'(x), 100);
        chk("relaunch_busy", int'(busy), 1);
        tick_frame(0);
        chk("relaunch_tick_x", int'(x), 97);

        // Slice and miss on the same tick: slice wins, then split exits silently.
        do_reset();
        drive(0, 1, 400, 0, 20, 0, 0);
        for (int i = 0; i < 40; i++) tick_frame(0);
        tick_frame(1);
        chk("prio_slice", int'(slice), 1);
        chk("prio_ys", int'(yslice), 768);
        chk("prio_no_miss", miss_cnt, 0);
        tick_frame(0);
        chk("split_exit_busy", int'(busy), 0);
        chk("split_exit_slice", int'(slice), 0);
        chk("split_exit_no_miss", miss_cnt, 0);

        // Top clamp: vy=63, plus left-edge x clamp.
        do_reset();
        drive(0, 1, 2, -5, 63, 0, 0);
        tick_frame(0);
        chk("left_clamp_x", int'(x), 0);
        for (int i = 2; i <= 13; i++) tick_frame(0);
        chk("top_y13", int'(y), 27);
        for (int i = 0; i < 4; i++) begin
            tick_frame(0);
            chk($sformatf("top_y%0d", 14 + i), int'(y), ef[i]);
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
